// File: rtl/overlap_add_pkg.sv
// overlap_add_pkg: shared types and helpers for the overlap-add reconstructor.
//   ola_state_e  : ACCUM / EMIT / FLUSH control states
//   ovl_factor() : ceil(FRAME_LEN/HOP_LEN), frames overlapping any one sample
//   ptr_w()      : width of a circular pointer into the accumulator bank
//   sat()        : clamp a signed value to a signed bw-bit range
package overlap_add_pkg;

  typedef enum logic [1:0] {ACCUM, EMIT, FLUSH} ola_state_e;

  function automatic int ovl_factor(input int frame_len, input int hop_len);
    return (frame_len + hop_len - 1) / hop_len;
  endfunction

  // A one-entry bank still needs a 1-bit pointer to keep port widths legal.
  function automatic int ptr_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/overlap_add_if.sv
// overlap_add_if: sample-in / sample-out bus of the overlap-add block.
//   di_en, data_i, flush        : upstream -> block
//   di_ready                    : block can take a sample
//   do_en, data_o, out_num, busy: reconstructed stream and status
// master = upstream/consumer side, slave = the block.
interface overlap_add_if #(
  parameter int I_BW   = 14,
  parameter int O_BW   = 14,
  parameter int CNT_BW = 17
);
  logic                     di_en;
  logic                     di_ready;
  logic signed [I_BW-1:0]   data_i;
  logic                     flush;
  logic                     do_en;
  logic signed [O_BW-1:0]   data_o;
  logic        [CNT_BW-1:0] out_num;
  logic                     busy;

  modport master (output di_en, data_i, flush,
                  input  di_ready, do_en, data_o, out_num, busy);
  modport slave  (input  di_en, data_i, flush,
                  output di_ready, do_en, data_o, out_num, busy);
endinterface

// File: rtl/overlap_add_acc.sv
// ola_acc_bank: single-port accumulator array with clear-on-read.
//   clk, rst : clock, synchronous active-low reset (clears every entry)
//   i_addr   : entry being accessed this cycle
//   i_add    : mem[i_addr] += sign-extended i_din (wraps at ACC_BW)
//   i_clr    : mem[i_addr] <= 0; o_dout shows the value before the clear
//   o_dout   : combinational read of mem[i_addr]
// i_add and i_clr are never asserted together by the controller; i_clr wins.
module ola_acc_bank #(
  parameter int DEPTH  = 1024,
  parameter int AW     = 10,
  parameter int ACC_BW = 18,
  parameter int I_BW   = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            i_addr,
  input  logic                     i_add,
  input  logic                     i_clr,
  input  logic signed [I_BW-1:0]   i_din,
  output logic signed [ACC_BW-1:0] o_dout
);

  logic signed [ACC_BW-1:0] r_mem [DEPTH];

  // Read is combinational so a sample written at one edge is emitted at the next.
  assign o_dout = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_mem[i_addr] <= '0;
    end else if (i_add) begin
      r_mem[i_addr] <= r_mem[i_addr] + ACC_BW'(i_din);
    end
  end

endmodule

// File: rtl/overlap_add.sv
// overlap_add: overlap-add reconstructor (inverse of framing).
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-low reset
//   bus  : overlap_add_if.slave
//          in : di_en, data_i, flush
//          out: di_ready (ACCUM only), do_en, data_o, out_num, busy (EMIT/FLUSH)
// Frames of FRAME_LEN samples are summed into a circular bank starting at
// base; after each frame HOP_LEN finished samples are read out (and cleared)
// and base advances by HOP_LEN. FLUSH drains the remaining tail.
module overlap_add
  import overlap_add_pkg::*;
#(
  parameter int FRAME_LEN  = 1024,
  parameter int HOP_LEN    = 160,
  parameter int I_BW       = 14,
  parameter int O_BW       = 14,
  parameter int ACC_BW     = 18,
  parameter int NORM_SHIFT = 0,
  parameter int CNT_BW     = 17
) (
  input  logic         clk,
  input  logic         rst,
  overlap_add_if.slave bus
);

  localparam int AW  = ptr_w(FRAME_LEN);
  localparam int OVL = ovl_factor(FRAME_LEN, HOP_LEN);

  if (HOP_LEN < 1 || HOP_LEN > FRAME_LEN) begin : g_hop_chk
    $error("overlap_add: HOP_LEN must be in 1..FRAME_LEN");
  end
  if (ACC_BW < I_BW + $clog2(OVL)) begin : g_acc_chk
    $error("overlap_add: ACC_BW lacks headroom for the overlap factor");
  end

  ola_state_e               r_state;
  logic [AW-1:0]            r_base;
  logic [AW-1:0]            r_fcnt;
  logic [AW-1:0]            r_ecnt;
  logic [CNT_BW-1:0]        r_emit_cnt;
  logic                     r_di_ready;
  logic                     r_busy;
  logic                     r_do_en;
  logic signed [O_BW-1:0]   r_data_o;
  logic [CNT_BW-1:0]        r_out_num;

  logic                     w_accept;
  logic [AW-1:0]            w_off;
  logic [AW-1:0]            w_addr;
  logic                     w_drain;
  logic                     w_last;
  logic signed [ACC_BW-1:0] w_rd;
  logic signed [63:0]       w_rd_ext;
  logic signed [63:0]       w_norm;
  logic signed [O_BW-1:0]   w_dout;

  // (a + b) mod FRAME_LEN; b may equal FRAME_LEN, hence the extra bit.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a,
                                             input logic [AW:0]   b);
    logic [AW+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s >= (AW+2)'(FRAME_LEN)) s = s - (AW+2)'(FRAME_LEN);
    return s[AW-1:0];
  endfunction

  assign w_accept = bus.di_en && r_di_ready;
  assign w_drain  = (r_state != ACCUM);
  // One address path: frame offset while accumulating, emit offset otherwise.
  assign w_off    = w_drain ? r_ecnt : r_fcnt;
  assign w_addr   = wrap_add(r_base, {1'b0, w_off});
  assign w_last   = (r_state == EMIT) ? (r_ecnt == AW'(HOP_LEN - 1))
                                      : (r_ecnt == AW'(FRAME_LEN - HOP_LEN - 1));

  ola_acc_bank #(
    .DEPTH  (FRAME_LEN),
    .AW     (AW),
    .ACC_BW (ACC_BW),
    .I_BW   (I_BW)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_addr),
    .i_add  (w_accept),
    .i_clr  (w_drain),
    .i_din  (bus.data_i),
    .o_dout (w_rd)
  );

  assign w_rd_ext = 64'(w_rd);
  assign w_norm   = w_rd_ext >>> NORM_SHIFT;
  assign w_dout   = O_BW'(sat(w_norm, O_BW));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ACCUM;
      r_base     <= '0;
      r_fcnt     <= '0;
      r_ecnt     <= '0;
      r_emit_cnt <= '0;
      r_di_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_do_en    <= 1'b0;
      r_data_o   <= '0;
      r_out_num  <= '0;
    end else begin
      r_do_en <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (r_fcnt == AW'(FRAME_LEN - 1)) begin
              r_fcnt     <= '0;
              r_ecnt     <= '0;
              r_state    <= EMIT;
              r_di_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end else if (bus.flush && r_fcnt == '0) begin
            // With no overlap there is no tail: only the pointer is reset.
            if (FRAME_LEN == HOP_LEN) begin
              r_base <= '0;
            end else begin
              r_ecnt     <= '0;
              r_state    <= FLUSH;
              r_di_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        EMIT, FLUSH: begin
          r_do_en    <= 1'b1;
          r_data_o   <= w_dout;
          r_out_num  <= r_emit_cnt;
          r_emit_cnt <= r_emit_cnt + 1'b1;
          r_ecnt     <= r_ecnt + 1'b1;
          if (w_last) begin
            r_state    <= ACCUM;
            r_di_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_base     <= (r_state == EMIT) ? wrap_add(r_base, (AW+1)'(HOP_LEN)) : '0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign bus.di_ready = r_di_ready;
  assign bus.busy     = r_busy;
  assign bus.do_en    = r_do_en;
  assign bus.data_o   = r_data_o;
  assign bus.out_num  = r_out_num;

endmodule

// File: tb/tb_overlap_add.sv
// tb_overlap_add: scoreboard bench for overlap_add (FRAME_LEN=8, HOP_LEN=2).
// A behavioural model queues expected {data_o, out_num} as samples are
// accepted or a flush is issued; a negedge monitor pops and compares.
module tb_overlap_add;

  localparam int FL  = 8;
  localparam int HL  = 2;
  localparam int IBW = 14;
  localparam int OBW = 14;
  localparam int ABW = 18;
  localparam int NS  = 0;
  localparam int CBW = 17;

  logic gclk = 1'b0;
  logic rst  = 1'b0;
  always #5 gclk = ~gclk;

  overlap_add_if #(.I_BW(IBW), .O_BW(OBW), .CNT_BW(CBW)) ifc();

  overlap_add #(
    .FRAME_LEN(FL), .HOP_LEN(HL), .I_BW(IBW), .O_BW(OBW),
    .ACC_BW(ABW), .NORM_SHIFT(NS), .CNT_BW(CBW)
  ) dut (
    .clk (gclk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct { int data; int num; } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  int m_acc [FL];
  int m_base, m_fcnt, m_cnt;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int msat(input int v);
    int hi, lo;
    hi = (1 << (OBW - 1)) - 1;
    lo = -(1 << (OBW - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < FL; i++) m_acc[i] = 0;
    m_base = 0;
    m_fcnt = 0;
    m_cnt  = 0;
  endfunction

  function automatic void push_out(input int n);
    for (int k = 0; k < n; k++) begin
      int idx;
      exp_t e;
      idx    = (m_base + k) % FL;
      e.data = msat(m_acc[idx] >>> NS);
      e.num  = m_cnt;
      sb.push_back(e);
      m_cnt      = (m_cnt + 1) % (1 << CBW);
      m_acc[idx] = 0;
    end
  endfunction

  function automatic void model_accept(input int v);
    m_acc[(m_base + m_fcnt) % FL] += v;
    if (m_fcnt == FL - 1) begin
      m_fcnt = 0;
      push_out(HL);
      m_base = (m_base + HL) % FL;
    end else begin
      m_fcnt++;
    end
  endfunction

  // Monitor: every valid output must match the head of the scoreboard.
  always @(negedge gclk) begin
    if (rst && ifc.do_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_o", ifc.data_o, e.data);
        chk("out_num", ifc.out_num, e.num);
      end
    end
  end

  task automatic do_reset();
    @(negedge gclk);
    rst = 1'b0;
    ifc.di_en = 1'b0;
    ifc.flush = 1'b0;
    @(negedge gclk);
    sb.delete();
    model_clear();
    rst = 1'b1;
  endtask

  // One sample, single-cycle di_en; retried while di_ready is low.
  task automatic send(input int v);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge gclk);
      ifc.di_en  = 1'b1;
      ifc.data_i = IBW'(v);
      if (ifc.di_ready) begin
        model_accept(v);
        ok = 1'b1;
        break;
      end
    end
    @(posedge gclk);
    #1 ifc.di_en = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic send_frames(input int v, input int nfr);
    for (int i = 0; i < nfr * FL; i++) send(v);
  endtask

  task automatic pulse_flush();
    @(negedge gclk);
    ifc.di_en = 1'b0;
    ifc.flush = 1'b1;
    if (ifc.di_ready && m_fcnt == 0) begin
      push_out(FL - HL);
      m_base = 0;
    end
    @(negedge gclk);
    ifc.flush = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge gclk);
      #1;
      if (sb.size() == 0 && !ifc.busy) break;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    int v, lowrun, nacc, bsum;
    ifc.di_en  = 1'b0;
    ifc.data_i = '0;
    ifc.flush  = 1'b0;
    model_clear();

    // Reset state
    repeat (3) @(negedge gclk);
    #1;
    chk("rst_do_en",    ifc.do_en, 0);
    chk("rst_data_o",   ifc.data_o, 0);
    chk("rst_out_num",  ifc.out_num, 0);
    chk("rst_di_ready", ifc.di_ready, 1);
    chk("rst_busy",     ifc.busy, 0);
    rst = 1'b1;

    // Steady state: 1,1,2,2,3,3,4,4,4,4
    send_frames(1, 5);
    drain();

    // Saturation both ways
    do_reset();
    send_frames(8191, 4);
    drain();
    send_frames(-8192, 4);
    drain();

    // Backpressure: di_en held high with a ramp
    do_reset();
    v = 0; lowrun = 0; nacc = 0;
    for (int t = 0; t < 300 && nacc < 3 * FL; t++) begin
      @(negedge gclk);
      ifc.di_en  = 1'b1;
      ifc.data_i = IBW'(v);
      if (ifc.di_ready) begin
        if (lowrun != 0) chk("bp_low", lowrun, HL);
        lowrun = 0;
        model_accept(v);
        v++;
        nacc++;
      end else begin
        lowrun++;
      end
    end
    chk("bp_accepts", nacc, 3 * FL);
    @(negedge gclk);
    ifc.di_en = 1'b0;
    lowrun = 0;
    for (int t = 0; t < 20 && !ifc.di_ready; t++) begin
      lowrun++;
      @(negedge gclk);
    end
    chk("bp_low_last", lowrun, HL);
    drain();

    // Flush after one frame, then base restarts at 0
    do_reset();
    send_frames(1, 1);
    drain();
    pulse_flush();
    bsum = int'(ifc.busy);
    repeat (12) begin
      @(negedge gclk);
      bsum += int'(ifc.busy);
    end
    chk("flush_busy_cycles", bsum, FL - HL);
    drain();
    send_frames(1, 1);
    drain();

    // Flush mid-frame is ignored
    do_reset();
    for (int i = 0; i < 3; i++) send(5);
    pulse_flush();
    #1;
    chk("ign_flush_busy",  ifc.busy, 0);
    chk("ign_flush_ready", ifc.di_ready, 1);
    for (int i = 3; i < FL; i++) send(5);
    drain();

    // Reset after the first output of a hop
    do_reset();
    send_frames(1, 1);
    for (int t = 0; t < 50; t++) begin
      @(negedge gclk);
      #1;
      if (sb.size() == HL - 1) break;
    end
    chk("mid_emit_reached", sb.size(), HL - 1);
    rst = 1'b0;
    @(negedge gclk);
    #1;
    chk("mid_rst_do_en",    ifc.do_en, 0);
    chk("mid_rst_out_num",  ifc.out_num, 0);
    chk("mid_rst_di_ready", ifc.di_ready, 1);
    chk("mid_rst_busy",     ifc.busy, 0);
    sb.delete();
    model_clear();
    rst = 1'b1;
    send_frames(1, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
